// File: rtl/washing_machine_pkg.sv
// washing_machine_pkg
// Shared definitions for the water heater controller.
//   TEMP_W                  : width of temperature values in degrees C
//   HYSTERESIS_DEFAULT      : default re-heat band below target
//   TIMEOUT_CYCLES_DEFAULT  : default maximum HEATING duration in clk cycles
//   heater_state_e          : controller state encoding
//   reheat_threshold()      : target minus hysteresis, 8-bit, saturating at 0
package washing_machine_pkg;

  localparam int TEMP_W                 = 7;
  localparam int HYSTERESIS_DEFAULT     = 2;
  localparam int TIMEOUT_CYCLES_DEFAULT = 6000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEATING = 2'd1,
    ST_HOLD    = 2'd2,
    ST_FAULT   = 2'd3
  } heater_state_e;

  // A target at or below the band yields 0, and nothing is below 0,
  // so such targets never re-heat.
  function automatic logic [7:0] reheat_threshold(input logic [TEMP_W-1:0] target,
                                                  input logic [7:0]        hyst);
    logic [7:0] t8;
    t8 = {1'b0, target};
    if (t8 <= hyst) begin
      reheat_threshold = 8'd0;
    end else begin
      reheat_threshold = t8 - hyst;
    end
  endfunction

endpackage

// File: rtl/heater_timeout_counter.sv
// heater_timeout_counter
// Counts cycles spent heating and flags when the limit is reached.
// Ports:
//   clk     in  : system clock
//   reset   in  : synchronous active-high reset
//   clear   in  : restart the count at zero (wins over enable)
//   enable  in  : count this cycle (controller is HEATING)
//   expired out : enable is high and the count has reached TIMEOUT_CYCLES-1
module heater_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 6000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_limit;

  assign at_limit = (count_q == LIMIT);
  assign expired  = enable && at_limit;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !at_limit) begin
      // Saturate at the limit so a held count cannot wrap.
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/water_heater_controller.sv
// water_heater_controller
// Heats water to a latched target, then holds it within a hysteresis band.
// Optional heating timeout enabled by defining HEATER_TIMEOUT_EN.
// Ports:
//   clk                  in  : system clock, rising edge
//   reset                in  : synchronous active-high reset
//   start                in  : begin a heating cycle (IDLE only)
//   stop                 in  : end the cycle or clear a fault
//   selected_temperature in  : target in degrees C, latched on start
//   measured_temperature in  : sensor reading in degrees C
//   sample_valid         in  : measured_temperature is valid this cycle
//   heater_on            out : heater element drive
//   temp_reached         out : high in HOLD
//   busy                 out : high in HEATING or HOLD
//   fault                out : high in FAULT (tied low without HEATER_TIMEOUT_EN)
//   state                out : current state encoding
module water_heater_controller
  import washing_machine_pkg::*;
#(
  parameter int HYSTERESIS     = HYSTERESIS_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [TEMP_W-1:0] selected_temperature,
  input  logic [TEMP_W-1:0] measured_temperature,
  input  logic              sample_valid,
  output logic              heater_on,
  output logic              temp_reached,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        state
);

  heater_state_e     state_q, state_d;
  logic [TEMP_W-1:0] target_q, target_d;
  logic              heater_q, heater_d;
  logic              temp_reached_q, temp_reached_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;

  logic [7:0] threshold;
  logic       at_target;
  logic       below_band;
  logic       timeout_hit;

  assign threshold  = reheat_threshold(target_q, 8'(HYSTERESIS));
  assign at_target  = sample_valid && (measured_temperature >= target_q);
  assign below_band = sample_valid && ({1'b0, measured_temperature} < threshold);

`ifdef HEATER_TIMEOUT_EN
  logic counter_clear;
  assign counter_clear = (state_q == ST_IDLE) && start && !stop;

  heater_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (counter_clear),
    .enable (state_q == ST_HEATING),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    heater_d = heater_q;
    case (state_q)
      ST_IDLE: begin
        heater_d = 1'b0;
        // stop wins over a same-cycle start.
        if (start && !stop) begin
          target_d = selected_temperature;
          if (selected_temperature == '0) begin
            state_d = ST_HOLD;
          end else begin
            state_d  = ST_HEATING;
            heater_d = 1'b1;
          end
        end
      end
      ST_HEATING: begin
        heater_d = 1'b1;
        if (stop) begin
          state_d  = ST_IDLE;
          heater_d = 1'b0;
        end else if (at_target) begin
          // Reaching target wins over a same-cycle timeout.
          state_d  = ST_HOLD;
          heater_d = 1'b0;
        end else if (timeout_hit) begin
          state_d  = ST_FAULT;
          heater_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_d  = ST_IDLE;
          heater_d = 1'b0;
        end else if (at_target) begin
          heater_d = 1'b0;
        end else if (below_band) begin
          heater_d = 1'b1;
        end
      end
      ST_FAULT: begin
        heater_d = 1'b0;
        if (stop) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        heater_d = 1'b0;
      end
    endcase

    // Status flags are registered from the next state so they move with it.
    temp_reached_d = (state_d == ST_HOLD);
    busy_d         = (state_d == ST_HEATING) || (state_d == ST_HOLD);
    fault_d        = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      target_q       <= '0;
      heater_q       <= 1'b0;
      temp_reached_q <= 1'b0;
      busy_q         <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      heater_q       <= heater_d;
      temp_reached_q <= temp_reached_d;
      busy_q         <= busy_d;
      fault_q        <= fault_d;
    end
  end

  assign heater_on    = heater_q;
  assign temp_reached = temp_reached_q;
  assign busy         = busy_q;
  assign state        = state_q;
`ifdef HEATER_TIMEOUT_EN
  assign fault        = fault_q;
`else
  assign fault        = 1'b0;
`endif

endmodule
